// File: rtl/cnn_fifo_pkg.sv
// Shared definitions for the CNN FIFO bank and its skewed reader.
// Holds default lane geometry, reader state encoding and a width helper.
package cnn_fifo_pkg;

  localparam int unsigned DATA_SIZE  = 16;
  localparam int unsigned ARRAY_SIZE = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/skew_lane_reg.sv
// One lane of the reader's output pipeline: registers the read enable to line up
// with FIFO dataOut, then registers zero-padded data and valid for the PEs.
module skew_lane_reg #(
  parameter int unsigned data_size = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [data_size-1:0] in_data,
  output logic [data_size-1:0] out_data,
  output logic                 out_valid
);

  logic rd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_q      <= rd_en;
      out_valid <= rd_q;
      // Idle lanes present zeros so the PE array sees clean padding.
      out_data  <= rd_q ? in_data : '0;
    end
  end

endmodule

// File: rtl/fifo_skew_reader.sv
// Reads the FIFO bank with a diagonal skew (lane i starts i steps after lane 0),
// stalling all lanes together whenever any active lane is empty.
module fifo_skew_reader
  import cnn_fifo_pkg::*;
#(
  parameter int unsigned data_size  = DATA_SIZE,
  parameter int unsigned array_size = ARRAY_SIZE,
  parameter int unsigned len_width  = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [len_width-1:0]            length,
  input  logic [array_size-1:0]           empty,
  output logic [array_size-1:0]           r_en,
  input  logic [data_size*array_size-1:0] in_bus,
  output logic [data_size*array_size-1:0] out_bus,
  output logic [array_size-1:0]           out_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned step_w = len_width + clog2(array_size);

  state_e               state_q, state_d;
  logic [step_w-1:0]    step_q, step_d;
  logic [len_width-1:0] len_q, len_d;
  logic                 drain_q, drain_d;

  logic [step_w-1:0]     last_step;
  logic [array_size-1:0] active;
  logic                  stall;

  // step_w leaves headroom so i + len_q never wraps.
  always_comb begin
    for (int unsigned i = 0; i < array_size; i++) begin
      active[i] = (step_q >= step_w'(i)) && (step_q < step_w'(i) + step_w'(len_q));
    end
  end

  assign last_step = step_w'(len_q) + step_w'(array_size) - step_w'(2);
  assign stall     = |(active & empty);
  assign r_en      = ((state_q == RUN) && !stall) ? active : '0;
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    len_d   = len_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            state_d = RUN;
            len_d   = length;
            step_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          if (step_q == last_step) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            step_d = step_q + step_w'(1);
          end
        end
      end
      // Two cycles: FIFO read latency, then the lane output register.
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      len_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      drain_q <= drain_d;
    end
  end

  for (genvar g = 0; g < array_size; g++) begin : g_lane
    skew_lane_reg #(
      .data_size(data_size)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (r_en[g]),
      .in_data  (in_bus[g*data_size +: data_size]),
      .out_data (out_bus[g*data_size +: data_size]),
      .out_valid(out_valid[g])
    );
  end

endmodule

// File: tb/tb_fifo_skew_reader.sv
// Bench for fifo_skew_reader: 3 lanes, a small FIFO bank model preloaded with
// lane i words 16'h{i}00..16'h{i}03, table-driven cycle checks and a data scoreboard.
module tb_fifo_skew_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned AS = 3;
  localparam int unsigned LW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] length = '0;
  logic [AS-1:0] empty, r_en, out_valid;
  logic [AS-1:0] force_e = '0;
  logic [DW*AS-1:0] in_bus, out_bus;
  logic          busy, done;
  logic          reload = 1'b0;

  logic [DW-1:0] dout [AS];
  int unsigned   level [AS];
  int unsigned   rptr [AS];
  logic          underflow = 1'b0;

  typedef logic [DW-1:0] word_q_t [$];
  word_q_t exp_q [AS];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rise [AS];
  logic [AS-1:0] prev_v = '0;

  typedef struct {
    logic          reload;
    logic          start;
    logic [LW-1:0] length;
    logic [AS-1:0] fe;
    logic [AS-1:0] ren;
    logic [AS-1:0] vld;
    logic          busy;
    logic          done;
  } vec_t;

  always #5 clk = ~clk;

  fifo_skew_reader #(
    .data_size (DW),
    .array_size(AS),
    .len_width (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .length   (length),
    .empty    (empty),
    .r_en     (r_en),
    .in_bus   (in_bus),
    .out_bus  (out_bus),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  // FIFO bank model: dataOut is valid one clock after r_en.
  always_comb begin
    for (int i = 0; i < AS; i++) begin
      empty[i] = (level[i] == 0) || force_e[i];
      in_bus[i*DW +: DW] = dout[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AS; i++) begin
        level[i] <= 0;
        rptr[i]  <= 0;
        dout[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < AS; i++) begin
        if (reload) begin
          level[i] <= 4;
          rptr[i]  <= 0;
        end else if (r_en[i]) begin
          if (level[i] == 0) begin
            underflow <= 1'b1;
          end else begin
            dout[i]  <= 16'(i * 256 + rptr[i]);
            rptr[i]  <= rptr[i] + 1;
            level[i] <= level[i] - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_run(input int len);
    for (int i = 0; i < AS; i++)
      for (int k = 0; k < len; k++) exp_q[i].push_back(16'(i * 256 + k));
  endtask

  // Wait to the sampling point and run the output scoreboard.
  task automatic tick();
    logic [DW-1:0] w;
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < AS; i++) begin
      w = out_bus[i*DW +: DW];
      if (out_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lane%0d_unexpected_word: got 0x%0h, expected no valid", i, w);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("lane%0d_data", i), 64'(w), 64'(e));
        end
        if (!prev_v[i]) rise[i] = cyc;
      end else begin
        chk($sformatf("lane%0d_pad_zero", i), 64'(w), 64'h0);
      end
      prev_v[i] = out_valid[i];
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rl, input logic st, input logic [LW-1:0] ln,
                              input logic [AS-1:0] fe, input logic [AS-1:0] ren,
                              input logic [AS-1:0] vld, input logic bs, input logic dn);
    vec_t v;
    v.reload = rl; v.start = st; v.length = ln; v.fe = fe;
    v.ren = ren; v.vld = vld; v.busy = bs; v.done = dn;
    return v;
  endfunction

  initial begin
    vec_t          vecs[$];
    logic [AS-1:0] ren_b [10];
    logic [AS-1:0] vld_b [10];
    logic [AS-1:0] ren_s [13];
    logic [AS-1:0] vld_s [13];
    logic [AS-1:0] ren_f [4];
    logic [AS-1:0] fe;
    int            dcnt, done_at;
    int            vcnt [AS];

    ren_b = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    vld_b = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000, 3'b000};
    ren_s = '{3'b001, 3'b011, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111, 3'b110, 3'b100,
              3'b000, 3'b000, 3'b000, 3'b000};
    vld_s = '{3'b000, 3'b000, 3'b001, 3'b011, 3'b000, 3'b000, 3'b000, 3'b111, 3'b111,
              3'b110, 3'b100, 3'b000, 3'b000};
    ren_f = '{3'b001, 3'b011, 3'b110, 3'b100};

    // Basic run, length 4.
    vecs.push_back(mk(1'b1, 1'b0, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 12'd4, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    for (int c = 0; c < 10; c++)
      vecs.push_back(mk(1'b0, 1'b0, 12'd4, 3'b000, ren_b[c], vld_b[c], c < 8, c == 8));
    // Lane 1 empty for 3 cycles at step 2.
    vecs.push_back(mk(1'b1, 1'b0, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 12'd4, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    for (int c = 0; c < 13; c++) begin
      fe = (c >= 2 && c <= 4) ? 3'b010 : 3'b000;
      vecs.push_back(mk(1'b0, 1'b0, 12'd4, fe, ren_s[c], vld_s[c], c < 11, c == 11));
    end
    // Empty flags on lanes that are not active must not stall.
    vecs.push_back(mk(1'b1, 1'b0, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 12'd4, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    for (int c = 0; c < 10; c++) begin
      fe = (c == 0) ? 3'b100 : ((c == 5) ? 3'b001 : 3'b000);
      vecs.push_back(mk(1'b0, 1'b0, 12'd4, fe, ren_b[c], vld_b[c], c < 8, c == 8));
    end
    // Zero length goes straight to DONE.
    vecs.push_back(mk(1'b0, 1'b1, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 12'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0));

    for (int i = 0; i < AS; i++) rise[i] = 0;

    #1 reset = 1'b1;
    #2;
    chk("reset_r_en", 64'(r_en), 64'h0);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_out_bus", 64'(out_bus), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_done", 64'(done), 64'h0);
    adv();
    reset = 1'b0;

    foreach (vecs[r]) begin
      reload  = vecs[r].reload;
      start   = vecs[r].start;
      length  = vecs[r].length;
      force_e = vecs[r].fe;
      if (vecs[r].start && vecs[r].length != 0) push_run(int'(vecs[r].length));
      tick();
      chk($sformatf("row%0d_r_en", r), 64'(r_en), 64'(vecs[r].ren));
      chk($sformatf("row%0d_out_valid", r), 64'(out_valid), 64'(vecs[r].vld));
      chk($sformatf("row%0d_busy", r), 64'(busy), 64'(vecs[r].busy));
      chk($sformatf("row%0d_done", r), 64'(done), 64'(vecs[r].done));
      adv();
    end
    reload = 1'b0; start = 1'b0; force_e = '0;
    chk("skew_lane1", 64'(rise[1] - rise[0]), 64'd1);
    chk("skew_lane2", 64'(rise[2] - rise[0]), 64'd2);
    for (int i = 0; i < AS; i++) chk($sformatf("table_lane%0d_drained", i), 64'(exp_q[i].size()), 64'd0);

    // Start while busy must be ignored.
    reload = 1'b1; tick(); adv(); reload = 1'b0;
    start = 1'b1; length = 12'd4; push_run(4); tick(); adv();
    dcnt = 0; done_at = -1;
    for (int i = 0; i < AS; i++) vcnt[i] = 0;
    for (int k = 0; k < 20; k++) begin
      start  = (k == 2);
      length = (k == 2) ? 12'd2 : 12'd4;
      tick();
      if (done) begin dcnt++; done_at = k; end
      for (int i = 0; i < AS; i++) if (out_valid[i]) vcnt[i]++;
      adv();
    end
    start = 1'b0;
    chk("busy_start_done_count", 64'(dcnt), 64'd1);
    chk("busy_start_done_cycle", 64'(done_at), 64'd8);
    for (int i = 0; i < AS; i++) chk($sformatf("busy_start_lane%0d_words", i), 64'(vcnt[i]), 64'd4);

    // Asynchronous reset at step 3.
    reload = 1'b1; tick(); adv(); reload = 1'b0;
    start = 1'b1; length = 12'd4; push_run(4); tick(); adv(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin tick(); adv(); end
    chk("pre_reset_r_en", 64'(r_en), 64'h7);
    chk("pre_reset_out_valid", 64'(out_valid), 64'h3);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_r_en", 64'(r_en), 64'h0);
    chk("async_reset_out_valid", 64'(out_valid), 64'h0);
    chk("async_reset_out_bus", 64'(out_bus), 64'h0);
    chk("async_reset_busy", 64'(busy), 64'h0);
    chk("async_reset_done", 64'(done), 64'h0);
    for (int i = 0; i < AS; i++) exp_q[i].delete();
    adv();
    reset = 1'b0;

    reload = 1'b1; tick(); adv(); reload = 1'b0;
    start = 1'b1; length = 12'd2; push_run(2); tick(); adv(); start = 1'b0;
    dcnt = 0; done_at = -1;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k < 4) chk($sformatf("post_reset_r_en_c%0d", k), 64'(r_en), 64'(ren_f[k]));
      if (done) begin dcnt++; done_at = k; end
      adv();
    end
    chk("post_reset_done_count", 64'(dcnt), 64'd1);
    chk("post_reset_done_cycle", 64'(done_at), 64'd6);
    for (int i = 0; i < AS; i++) chk($sformatf("final_lane%0d_drained", i), 64'(exp_q[i].size()), 64'd0);
    chk("fifo_underflow", 64'(underflow), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
